// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and its alignment checker:
// FSM state encoding, access-size masks and the sign-extend bit position.
package dmem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] MASK_BYTE = 3'b001;
  localparam logic [2:0] MASK_HALF = 3'b011;
  localparam logic [2:0] MASK_WORD = 3'b111;

  localparam int SIGN_BIT = 3;

endpackage

// File: rtl/dmem_align_chk.sv
// Combinational legality/alignment check of a data-memory access given the
// low address bits and the size field of sign_mask.
module dmem_align_chk
  import dmem_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  logic [2:0] size_mask,
  output logic       legal,
  output logic       misaligned
);

  always_comb begin
    legal      = (size_mask == MASK_BYTE) || (size_mask == MASK_HALF) ||
                 (size_mask == MASK_WORD);
    misaligned = 1'b0;
    if (size_mask == MASK_HALF) begin
      misaligned = addr_lo[0];
    end else if (size_mask == MASK_WORD) begin
      misaligned = (addr_lo != 2'b00);
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single data_mem: grants one requester, checks
// alignment, issues a one-cycle read/write pulse and follows clk_stall to completion.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 64,
  parameter bit P0_PRIORITY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we0,
  input  logic [3:0]        sign_mask0,
  output logic [DATA_W-1:0] rdata0,
  output logic              ack0,
  output logic              err0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we1,
  input  logic [3:0]        sign_mask1,
  output logic [DATA_W-1:0] rdata1,
  output logic              ack1,
  output logic              err1,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_memwrite,
  output logic              mem_memread,
  output logic [3:0]        mem_sign_mask,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_clk_stall
);

  localparam int TMO_W = $clog2(TIMEOUT);

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              rr_q, rr_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic winner;
  logic legal, misaligned;
  logic ack_w, err_w, rd_w, wr_w;

  dmem_align_chk u_align_chk (
    .addr_lo    (addr_q[1:0]),
    .size_mask  (mask_q[2:0]),
    .legal      (legal),
    .misaligned (misaligned)
  );

  // rr_q names the port that wins the next tie; a lone requester always wins.
  always_comb begin
    if (req0 && req1) begin
      winner = P0_PRIORITY ? 1'b0 : rr_q;
    end else begin
      winner = !req0;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    mask_d   = mask_q;
    tmo_d    = tmo_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    ack_w    = 1'b0;
    err_w    = 1'b0;
    rd_w     = 1'b0;
    wr_w     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          grant_d = winner;
          rr_d    = !winner;
          we_d    = winner ? we1        : we0;
          addr_d  = winner ? addr1      : addr0;
          wdata_d = winner ? wdata1     : wdata0;
          mask_d  = winner ? sign_mask1 : sign_mask0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (!legal || misaligned) begin
          err_w   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        rd_w    = !we_q;
        wr_w    = we_q;
        tmo_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A clear stall always completes, even on the last allowed cycle.
        if (!mem_clk_stall) begin
          if (!we_q) begin
            if (grant_q) rdata1_d = mem_read_data;
            else         rdata0_d = mem_read_data;
          end
          state_d = ST_DONE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_w   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_DONE: begin
        ack_w   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= 1'b0;
      rr_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      mask_q   <= '0;
      tmo_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      mask_q   <= mask_d;
      tmo_q    <= tmo_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign busy           = (state_q != ST_IDLE);
  assign ack0           = ack_w && !grant_q;
  assign ack1           = ack_w &&  grant_q;
  assign err0           = err_w && !grant_q;
  assign err1           = err_w &&  grant_q;
  assign rdata0         = rdata0_q;
  assign rdata1         = rdata1_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign mem_sign_mask  = mask_q;
  assign mem_memread    = rd_w;
  assign mem_memwrite   = wr_w;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a stalling data_mem model, a byte-array reference
// model of memory, directed spec scenarios and a randomized transaction run.
module tb_data_mem_arbiter;

  localparam int TMO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic [3:0]  sm0 = 0, sm1 = 0;
  logic [31:0] rdata0, rdata1, mem_addr, mem_write_data, mem_read_data;
  logic        ack0, ack1, err0, err1, busy, mem_memwrite, mem_memread, mem_clk_stall;
  logic [3:0]  mem_sign_mask;

  logic        b_req0 = 0, b_req1 = 0;
  logic [31:0] b_rdata0, b_rdata1, b_mem_addr, b_mem_write_data;
  logic        b_ack0, b_ack1, b_err0, b_err1, b_busy, b_mem_memwrite, b_mem_memread;
  logic [3:0]  b_mem_sign_mask;

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .P0_PRIORITY(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .sign_mask0(sm0),
    .rdata0(rdata0), .ack0(ack0), .err0(err0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .sign_mask1(sm1),
    .rdata1(rdata1), .ack1(ack1), .err1(err1),
    .busy(busy), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
    .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
  );

  data_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO), .P0_PRIORITY(1'b1)) dut_p0 (
    .clk(clk), .rst_n(rst_n),
    .req0(b_req0), .addr0(addr0), .wdata0(wdata0), .we0(we0), .sign_mask0(sm0),
    .rdata0(b_rdata0), .ack0(b_ack0), .err0(b_err0),
    .req1(b_req1), .addr1(addr1), .wdata1(wdata1), .we1(we1), .sign_mask1(sm1),
    .rdata1(b_rdata1), .ack1(b_ack1), .err1(b_err1),
    .busy(b_busy), .mem_addr(b_mem_addr), .mem_write_data(b_mem_write_data),
    .mem_memwrite(b_mem_memwrite), .mem_memread(b_mem_memread), .mem_sign_mask(b_mem_sign_mask),
    .mem_read_data(32'h0), .mem_clk_stall(1'b0)
  );

  // data_mem model: acts on the pulse, then stalls for stall_len cycles
  logic [7:0]  dmem [0:4095] = '{default: 8'h00};
  int          stall_len = 0;
  int          stall_cnt = 0;
  int          pulse_cnt = 0;
  logic [31:0] mrd = 32'h0;
  logic [3:0]  last_mask = 4'h0;
  logic        last_wr = 1'b0;

  assign mem_clk_stall = (stall_cnt > 0);
  assign mem_read_data = mrd;

  function automatic logic [31:0] mdl_read(logic [31:0] a, logic [3:0] m);
    logic [7:0] b0, b1, b2, b3;
    logic [31:0] v;
    b0 = dmem[(a + 0) & 4095];
    b1 = dmem[(a + 1) & 4095];
    b2 = dmem[(a + 2) & 4095];
    b3 = dmem[(a + 3) & 4095];
    case (m[2:0])
      3'b001:  v = {{24{m[3] & b0[7]}}, b0};
      3'b011:  v = {{16{m[3] & b1[7]}}, b1, b0};
      default: v = {b3, b2, b1, b0};
    endcase
    return v;
  endfunction

  always @(posedge clk) begin
    if (mem_memwrite) begin
      for (int i = 0; i < 4; i++) begin
        if (i == 0 || (i == 1 && mem_sign_mask[1]) || (i >= 2 && mem_sign_mask[2]))
          dmem[(mem_addr + i) & 4095] <= mem_write_data[8*i +: 8];
      end
    end
    if (mem_memread) mrd <= mdl_read(mem_addr, mem_sign_mask);
    if (mem_memread || mem_memwrite) begin
      stall_cnt <= stall_len;
      pulse_cnt <= pulse_cnt + 1;
      last_mask <= mem_sign_mask;
      last_wr   <= mem_memwrite;
    end else if (stall_cnt > 0) begin
      stall_cnt <= stall_cnt - 1;
    end
  end

  // Reference model: plain byte array plus per-port expected read-back
  logic [7:0]  ref_mem [0:4095] = '{default: 8'h00};
  logic [31:0] exp_rdata [0:1] = '{32'h0, 32'h0};
  int          last_grant = 1;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int nbytes(logic [2:0] m);
    if (m == 3'b111) return 4;
    if (m == 3'b011) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] a, logic [3:0] m);
    int n;
    logic [31:0] v;
    n = nbytes(m[2:0]);
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[(a + i) & 4095]) << (8 * i));
    if (m[3] && n < 4) v = 32'($signed(v << (32 - 8 * n)) >>> (32 - 8 * n));
    return v;
  endfunction

  function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endfunction

  task automatic drive_port(input int p, input logic r, input logic [31:0] a,
                            input logic [31:0] wd, input logic w, input logic [3:0] m);
    if (p == 0) begin req0 = r; addr0 = a; wdata0 = wd; we0 = w; sm0 = m; end
    else        begin req1 = r; addr1 = a; wdata1 = wd; we1 = w; sm1 = m; end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_ackerr"}, {28'h0, ack0, ack1, err0, err1}, 0);
    check({tag, "_rdpulse"}, {30'h0, mem_memread, mem_memwrite}, 0);
    check({tag, "_maddr"}, mem_addr, 0);
    check({tag, "_mwdata"}, mem_write_data, 0);
    check({tag, "_mmask"}, 32'(mem_sign_mask), 0);
    check({tag, "_rdata0"}, rdata0, 0);
    check({tag, "_rdata1"}, rdata1, 0);
  endtask

  // One transaction on port p; expectations derived from the access rules
  task automatic run_txn(input string tag, input int p, input logic [31:0] a,
                         input logic [31:0] wd, input logic w, input logic [3:0] m, input int st);
    bit chk_err, tmo, done, side;
    int lat, n, p0;
    logic a_p, e_p;
    chk_err = !(m[2:0] inside {3'b001, 3'b011, 3'b111}) ||
              (m[2:0] == 3'b011 && a[0]) || (m[2:0] == 3'b111 && a[1:0] != 2'b00);
    tmo = !chk_err && (st >= TMO);
    lat = chk_err ? 1 : (tmo ? 2 + TMO : 4 + st);
    if (!chk_err && w) begin
      for (int i = 0; i < nbytes(m[2:0]); i++) ref_mem[(a + i) & 4095] = wd[8*i +: 8];
    end
    if (!chk_err && !tmo && !w) exp_rdata[p] = ref_load(a, m);
    stall_len = st;
    p0 = pulse_cnt;
    drive_port(p, 1'b1, a, wd, w, m);
    n = 0; done = 0; side = 0;
    while (!done && n < 300) begin
      @(posedge clk); #1; n++;
      a_p = (p == 0) ? ack0 : ack1;
      e_p = (p == 0) ? err0 : err1;
      if ((p == 0 ? (ack1 | err1) : (ack0 | err0)) || (a_p && e_p)) side = 1;
      if (a_p || e_p) begin
        done = 1;
        drive_port(p, 1'b0, a, wd, w, m);
        check({tag, "_lat"}, lat, n);
        check({tag, "_err"}, 32'(e_p), 32'(chk_err || tmo));
        check({tag, "_rdata0"}, rdata0, exp_rdata[0]);
        check({tag, "_rdata1"}, rdata1, exp_rdata[1]);
      end
    end
    drive_port(p, 1'b0, a, wd, w, m);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_side"}, 32'(side), 0);
    last_grant = p;
    @(posedge clk); #1;
    check({tag, "_pulses"}, pulse_cnt - p0, chk_err ? 0 : 1);
    check({tag, "_idle"}, 32'(busy), 0);
  endtask

  logic [3:0] mtab [0:8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1001, 4'b1011,
                             4'b1111, 4'b0101, 4'b0000, 4'b1110};

  initial begin
    int n, w;
    bit got;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte store with 3 stall cycles
    run_txn("t1_st", 0, 32'h400, 32'hAA, 1'b1, 4'b0001, 3);
    check("t1_mask", 32'(last_mask), 32'h1);
    check("t1_wr", 32'(last_wr), 1);

    // Signed and unsigned byte loads
    run_txn("t2_sx", 0, 32'h400, 32'h0, 1'b0, 4'b1001, 0);
    check("t2_sx_val", rdata0, 32'hFFFFFFAA);
    run_txn("t2_zx", 0, 32'h400, 32'h0, 1'b0, 4'b0001, 1);
    check("t2_zx_val", rdata0, 32'h000000AA);

    // Misaligned half and illegal mask on port 1
    run_txn("t3_mis", 1, 32'h101, 32'h0, 1'b0, 4'b0011, 0);
    run_txn("t3_ill", 1, 32'h100, 32'h0, 1'b0, 4'b0101, 0);

    // Round-robin ties with both requests held
    run_txn("t4_pre", 0, 32'h10, 32'h11223344, 1'b1, 4'b0111, 0);
    run_txn("t4_pre1", 1, 32'h20, 32'h8899AABB, 1'b1, 4'b0111, 0);
    stall_len = 1;
    drive_port(0, 1'b1, 32'h10, 32'h0, 1'b0, 4'b0111);
    drive_port(1, 1'b1, 32'h20, 32'h0, 1'b0, 4'b1111);
    for (int k = 0; k < 4; k++) begin
      n = 0; got = 0;
      while (!got && n < 300) begin
        @(posedge clk); #1; n++;
        if (ack0 || ack1) got = 1;
      end
      check("t4_done", 32'(got), 1);
      w = ack1 ? 1 : 0;
      check("t4_rr", w, 1 - last_grant);
      check("t4_seq", w, k % 2);
      last_grant = w;
      exp_rdata[w] = ref_load(w ? 32'h20 : 32'h10, 4'b0111);
      check("t4_rdata", w ? rdata1 : rdata0, exp_rdata[w]);
      if (k == 3) begin req0 = 0; req1 = 0; end
    end
    @(posedge clk); #1;

    // Fixed priority: port 0 wins every tie, port 1 served once port 0 drops
    b_req0 = 1; b_req1 = 1;
    for (int k = 0; k < 5; k++) begin
      n = 0; got = 0;
      while (!got && n < 100) begin
        @(posedge clk); #1; n++;
        if (b_ack0 || b_ack1) got = 1;
      end
      check("t4b_done", 32'(got), 1);
      check("t4b_win", 32'(b_ack1), (k == 4) ? 1 : 0);
      if (k == 3) b_req0 = 0;
      if (k == 4) b_req1 = 0;
    end
    @(posedge clk); #1;
    check("t4b_err", {30'h0, b_err0, b_err1}, 0);

    // Randomized transactions against the reference model
    for (int k = 0; k < 24; k++) begin
      run_txn("rnd", int'($urandom_range(0, 1)), 32'($urandom_range(0, 255)), $urandom,
              1'($urandom_range(0, 1)), mtab[$urandom_range(0, 8)], int'($urandom_range(0, 4)));
    end

    // Timeout boundaries
    run_txn("t5_63", 0, 32'h40, 32'h0, 1'b0, 4'b0111, TMO - 1);
    run_txn("t5_64", 0, 32'h44, 32'h0, 1'b0, 4'b0111, TMO);
    run_txn("t5_100", 1, 32'h48, 32'h0, 1'b0, 4'b0111, 100);

    // Reset during WAIT, then a normal access
    stall_len = 10;
    drive_port(1, 1'b1, 32'h40, 32'h0, 1'b0, 4'b0111);
    repeat (4) begin @(posedge clk); #1; end
    check("t6_busy", 32'(busy), 1);
    check("t6_stall", 32'(mem_clk_stall), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_rst");
    req1 = 0;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    last_grant = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_txn("t6_after", 0, 32'h10, 32'h0, 1'b0, 4'b0111, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
